wb_regfile: RTL and testbench

// - Write-back stage and register file of the 5-stage MIPS pipeline.
// - Consumes the Memory-WriteBack pipeline register outputs and selects ALU result or load data.
// - Writes the selected value into a 32x32 GPR array; $0 is hardwired to zero.
// - Serves the two combinational read ports used by decode, and counts retired register writes.

---
 rtl/wb_regfile.sv | 118 +++++++++++
 tb/tb_wb_regfile.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Write-back stage and 32x32 general-purpose register file for
//               a 5-stage MIPS pipeline. Selects the ALU result or the load
//               data from the MEM/WB pipeline register and writes it into the
//               GPR array. Register $0 reads as zero and has no storage.
//               Provides two combinational read ports for decode and counts
//               retired (non-$0) register writes.
//
//               Optional feature macro: WB_BYPASS_EN
//                 defined   - a read port addressing the register being
//                             written this cycle returns the write-back
//                             value (write-before-read).
//                 undefined - read ports return stored contents only.
//
// Ports       : clk          in   rising-edge clock
//               reset        in   asynchronous active-low reset
//               reg_wr_i     in   write enable from WB pipe register
//               mem_to_reg_i in   1: write read_data_i, 0: write res_alu_i
//               rd_i         in   destination register index
//               res_alu_i    in   ALU result
//               read_data_i  in   load data
//               rs_addr_i    in   read port A index
//               rt_addr_i    in   read port B index
//               rs_data_o    out  read port A data
//               rt_data_o    out  read port B data
//               wb_data_o    out  selected write-back value
//               wb_count_o   out  retired non-$0 register writes (wrapping)
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_wr_i,
    input  logic              mem_to_reg_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] res_alu_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [CNT_W-1:0]  wb_count_o
);

    localparam int c_NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_view [c_NREG];
    logic              w_byp_rs;
    logic              w_byp_rt;
    logic [CNT_W-1:0]  r_wb_count;

    // Write-back select: purely combinational, also feeds forwarding.
    assign w_wb_data = mem_to_reg_i ? read_data_i : res_alu_i;

    // Writes to $0 are architectural no-ops and are not counted.
    assign w_wr_en   = reg_wr_i && (rd_i != '0);

    // ------------------------------------------------------------------------
    // GPR array. Entry 0 is a constant zero, not a flop; entries 1..N-1 are
    // individual registers so reset clears every one of them asynchronously.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < c_NREG; gi++) begin : g_gpr
        if (gi == 0) begin : g_zero
            assign w_view[gi] = '0;
        end else begin : g_reg
            logic [DATA_W-1:0] r_gpr;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_gpr <= '0;
                end else if (w_wr_en && (rd_i == ADDR_W'(gi))) begin
                    r_gpr <= w_wb_data;
                end
            end

            assign w_view[gi] = r_gpr;
        end
    end

    // ------------------------------------------------------------------------
    // Same-cycle bypass. Gated with reset so that reads stay zero while reset
    // is asserted, and with w_wr_en so that $0 never bypasses.
    // ------------------------------------------------------------------------
`ifdef WB_BYPASS_EN
    assign w_byp_rs = reset && w_wr_en && (rs_addr_i == rd_i);
    assign w_byp_rt = reset && w_wr_en && (rt_addr_i == rd_i);
`else
    assign w_byp_rs = 1'b0;
    assign w_byp_rt = 1'b0;
`endif

    assign rs_data_o = w_byp_rs ? w_wb_data : w_view[rs_addr_i];
    assign rt_data_o = w_byp_rt ? w_wb_data : w_view[rt_addr_i];
    assign wb_data_o = w_wb_data;

    // Retired-write counter; wraps naturally at 2**CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_count <= '0;
        end else if (w_wr_en) begin
            r_wb_count <= r_wb_count + 1'b1;
        end
    end

    assign wb_count_o = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. A driver applies one
//               stimulus set per cycle, computes the expected outputs from an
//               array-based architectural model and queues them; a monitor
//               pops and compares against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        reg_wr;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] res_alu;
    logic [31:0] read_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic [15:0] wb_count;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .reg_wr_i     (reg_wr),
        .mem_to_reg_i (mem_to_reg),
        .rd_i         (rd),
        .res_alu_i    (res_alu),
        .read_data_i  (read_data),
        .rs_addr_i    (rs_addr),
        .rt_addr_i    (rt_addr),
        .rs_data_o    (rs_data),
        .rt_data_o    (rt_data),
        .wb_data_o    (wb_data),
        .wb_count_o   (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wb;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Architectural model: plain array of register values plus an integer count.
    logic [31:0] m_gpr [32];
    int          m_cnt;

    function automatic logic [31:0] model_read(input logic [4:0] a,
                                               input logic wr, input logic [4:0] d,
                                               input logic [31:0] v);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wr && d != 5'd0 && a == d) return v;
`endif
        return m_gpr[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_cnt = 0;
    endtask

    // One cycle of stimulus, applied at the falling edge.
    task automatic cycle(input logic r, input logic wr, input logic m2r,
                         input logic [4:0] d, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [4:0] a,
                         input logic [4:0] b, input string tag);
        exp_t e;
        logic [31:0] v;
        @(negedge clk);
        rst_n = r; reg_wr = wr; mem_to_reg = m2r; rd = d;
        res_alu = alu; read_data = ld; rs_addr = a; rt_addr = b;
        v = m2r ? ld : alu;
        e.tag = tag;
        e.wb  = v;
        if (!r) begin
            model_clear();
            e.rs = 32'd0; e.rt = 32'd0; e.cnt = 16'd0;
        end else begin
            e.rs  = model_read(a, wr, d, v);
            e.rt  = model_read(b, wr, d, v);
            e.cnt = 16'(m_cnt);
            if (wr && d != 5'd0) begin
                m_gpr[d] = v;
                m_cnt    = (m_cnt + 1) % 65536;
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] a, input logic [4:0] b, input string tag);
        cycle(1'b1, 1'b0, $urandom_range(0, 1), 5'($urandom), $urandom, $urandom, a, b, tag);
    endtask

    // Monitor: compares the queued expectation 2 time units after each stimulus.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks += 4;
                if (rs_data !== e.rs) begin
                    n_fail++;
                    $display("FAIL %s rs_data actual=%h required=%h", e.tag, rs_data, e.rs);
                end
                if (rt_data !== e.rt) begin
                    n_fail++;
                    $display("FAIL %s rt_data actual=%h required=%h", e.tag, rt_data, e.rt);
                end
                if (wb_data !== e.wb) begin
                    n_fail++;
                    $display("FAIL %s wb_data actual=%h required=%h", e.tag, wb_data, e.wb);
                end
                if (wb_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s wb_count actual=%h required=%h", e.tag, wb_count, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [4:0] d, a, b;
        rst_n = 1'b0; reg_wr = 1'b0; mem_to_reg = 1'b0; rd = '0;
        res_alu = '0; read_data = '0; rs_addr = '0; rt_addr = '0;
        model_clear();

        // Reset state, including a write attempted while reset is held.
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd31, "reset");
        cycle(1'b0, 1'b1, 1'b0, 5'd9, 32'h55AA55AA, 32'd0, 5'd9, 5'd9, "reset_wr_drop");
        idle(5'd9, 5'd0, "after_reset_read");

        // ALU write then read back.
        cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 32'h11111111, 5'd3, 5'd0, "alu_wr");
        idle(5'd3, 5'd3, "alu_rd");
        // Load write to $31.
        cycle(1'b1, 1'b1, 1'b1, 5'd31, 32'h0, 32'hCAFEF00D, 5'd0, 5'd31, "ld_wr");
        idle(5'd3, 5'd31, "ld_rd");
        // Write to $0 is discarded and not counted.
        cycle(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, "r0_wr");
        idle(5'd0, 5'd0, "r0_rd");
        // Same-cycle write/read of $7.
        cycle(1'b1, 1'b1, 1'b0, 5'd7, 32'h00000001, 32'h0, 5'd1, 5'd2, "r7_pre");
        cycle(1'b1, 1'b1, 1'b0, 5'd7, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7, "r7_same");
        idle(5'd7, 5'd7, "r7_next");

        // Randomized traffic with a small hot set of indices to provoke overlaps.
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a = ($urandom_range(0, 2) == 0) ? d : 5'($urandom);
            b = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 3));
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
                  $urandom, $urandom, a, b, "random");
        end

        // Asynchronous reset mid-run with $5 holding 0x1234.
        cycle(1'b1, 1'b1, 1'b0, 5'd5, 32'h00001234, 32'h0, 5'd0, 5'd0, "r5_wr");
        idle(5'd5, 5'd3, "r5_rd");
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31, "async_reset");
        idle(5'd5, 5'd3, "post_reset");

        // Counter wrap: 65535 writes, one more to $2 wraps to zero, then holds.
        for (int i = 0; i < 65535; i++) begin
            cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)),
                  $urandom, $urandom, 5'($urandom), 5'($urandom), "wrap_fill");
        end
        cycle(1'b1, 1'b1, 1'b0, 5'd2, 32'h0BADF00D, 32'h0, 5'd2, 5'd0, "wrap_last");
        for (int i = 0; i < 4; i++) idle(5'd2, 5'($urandom), "wrap_hold");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #5;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
